mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares one synchronous port of the j1a dual-port program/data RAM between two requesters: the CPU data path (requester C) and the serial loader/debug monitor (requester L). C has priority. A starvation counter guarantees L forward progress. A lock mode lets L own the port exclusively for bulk image loads. The block sits between both requesters and RAM port B and adds no latency beyond the RAM's own one-cycle read.

## Interface
- LOG2ABITS, 11, RAM address width (2^LOG2ABITS words)
- DWIDTH, 16, data word width
- STARVE_LIMIT, 8, conflicting C wins tolerated before L is forced through; legal range 0..255
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- c_req  in  1  C access request, held until c_gnt
- c_we  in  1  C write (1) / read (0)
- c_addr  in  LOG2ABITS  C word address
- c_wdata  in  DWIDTH  C write data
- c_gnt  out  1  C access accepted this cycle
- c_rvalid  out  1  c_rdata valid (cycle after a granted C read)
- c_rdata  out  DWIDTH  read data to C
- l_req, l_we, l_addr, l_wdata  in  1/1/LOG2ABITS/DWIDTH  L request, same meaning as C
- l_lock  in  1  L requests exclusive ownership
- l_gnt, l_rvalid, l_rdata  out  1/1/DWIDTH  L response, same meaning as C
- m_addr  out  LOG2ABITS  RAM port address
- m_we  out  1  RAM port write enable
- m_wdata  out  DWIDTH  RAM port write data
- m_rdata  in  DWIDTH  RAM port registered read data

## Operation
- Handshake: a transfer occurs in any cycle where req and gnt are both 1. Grants are combinational from current req inputs and registered state. Requesters hold req/we/addr/wdata stable until granted.
- At most one of c_gnt/l_gnt is 1 in any cycle.
- Port mux:
  - m_addr/m_wdata come from the granted requester; with no grant they come from C.
  - m_we = (c_gnt & c_we) | (l_gnt & l_we).
- FSM state SHARE (reset state):
  - C only: c_gnt = 1.
  - L only: l_gnt = 1.
  - Both, starve_cnt < STARVE_LIMIT: c_gnt = 1; starve_cnt increments.
  - Both, starve_cnt >= STARVE_LIMIT: l_gnt = 1.
  - Any l_gnt clears starve_cnt to 0.
  - starve_cnt saturates at STARVE_LIMIT.
  - l_gnt & l_lock moves to LOCKED.
- FSM state LOCKED:
  - c_gnt = 0; l_gnt = l_req.
  - starve_cnt held at 0.
  - l_lock == 0 returns to SHARE on the next edge. The lock-release cycle is still LOCKED.
- Read tracking:
  - Registered flag rd_c = c_gnt & ~c_we, and rd_l = l_gnt & ~l_we.
  - c_rvalid = rd_c; l_rvalid = rd_l.
  - c_rdata and l_rdata are both wired to m_rdata and are meaningful only while the matching rvalid is 1.
- Writes produce no rvalid. A write does not update m_rdata (RAM is write-without-read).
- Reset: asynchronous, clears FSM to SHARE, starve_cnt to 0, and rd_c/rd_l to 0. While reset is 1, c_gnt, l_gnt and m_we are forced to 0.

## Timing
- Grant: same cycle as req when eligible, 0 wait states.
- Read latency: data and rvalid one cycle after the grant cycle. Back-to-back reads give one word per cycle.
- Write: takes effect at the edge ending the grant cycle. A read of the same address in the next cycle returns the new data.
- Worst-case L wait in SHARE under continuous C traffic: STARVE_LIMIT+1 cycles.
- Reset asserted mid-read: the pending rvalid is dropped and never appears after reset.
- Reset outputs: c_gnt = l_gnt = c_rvalid = l_rvalid = m_we = 0; m_addr = c_addr; m_wdata = c_wdata.

## Test plan
- C read alone: c_req = 1, c_we = 0, c_addr = 0x010 with RAM[0x010] = 0x6180 -> c_gnt in the same cycle; c_rvalid = 1 and c_rdata = 0x6180 the next cycle; l_rvalid stays 0.
- C write, then read back: write 0xBEEF to 0x7FF, then read 0x7FF on the following cycle -> m_we = 1 only in the write cycle; c_rdata = 0xBEEF with c_rvalid in the cycle after the read grant.
- Starvation, STARVE_LIMIT = 8: C and L request continuously -> 8 c_gnt cycles, then 1 l_gnt, then 8 c_gnt again. Pattern repeats with period 9; no cycle has both grants.
- Lock: L asserts l_lock with l_req while C requests continuously -> after the first l_gnt, c_gnt stays 0 for the whole lock, including during L idle cycles. Drop l_lock -> C granted on the second cycle after the drop.
- Simultaneous read responses: L granted a read of 0x100 (0x1234), C granted a read of 0x101 (0x5678) in the next cycle -> l_rvalid with 0x1234 and c_rvalid with 0x5678 in consecutive cycles, never both in one cycle.
- Reset mid-operation: assert reset in the cycle after a C read grant -> c_rvalid = 0 immediately and held; after release, FSM is in SHARE and starve_cnt = 0. Verify the counter by running the starvation pattern, whose first l_gnt must come after exactly 8 C grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between the CPU data path (C, priority) and the
// serial loader/debug monitor (L), with starvation relief and an exclusive lock mode.
module mem_port_arbiter #(
  parameter int LOG2ABITS    = 11,
  parameter int DWIDTH       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [LOG2ABITS-1:0] c_addr,
  input  logic [DWIDTH-1:0]    c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [DWIDTH-1:0]    c_rdata,
  input  logic                 l_req,
  input  logic                 l_we,
  input  logic [LOG2ABITS-1:0] l_addr,
  input  logic [DWIDTH-1:0]    l_wdata,
  input  logic                 l_lock,
  output logic                 l_gnt,
  output logic                 l_rvalid,
  output logic [DWIDTH-1:0]    l_rdata,
  output logic [LOG2ABITS-1:0] m_addr,
  output logic                 m_we,
  output logic [DWIDTH-1:0]    m_wdata,
  input  logic [DWIDTH-1:0]    m_rdata
);

  localparam logic [0:0] SHARE  = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

  logic [0:0] r_state;
  logic [7:0] r_starveCnt;
  logic       r_rdC;
  logic       r_rdL;

  logic       w_cGnt;
  logic       w_lGnt;
  logic       w_conflict;

  // Grants are purely combinational so an eligible requester sees zero wait states.
  always_comb begin
    w_cGnt     = 1'b0;
    w_lGnt     = 1'b0;
    w_conflict = c_req & l_req;
    if (!reset) begin
      if (r_state == LOCKED) begin
        w_lGnt = l_req;
      end else if (w_conflict) begin
        if (r_starveCnt < LIMIT) begin
          w_cGnt = 1'b1;
        end else begin
          w_lGnt = 1'b1;
        end
      end else begin
        w_cGnt = c_req;
        w_lGnt = l_req;
      end
    end
  end

  assign c_gnt   = w_cGnt;
  assign l_gnt   = w_lGnt;
  assign m_addr  = w_lGnt ? l_addr : c_addr;
  assign m_wdata = w_lGnt ? l_wdata : c_wdata;
  assign m_we    = (w_cGnt & c_we) | (w_lGnt & l_we);

  assign c_rvalid = r_rdC;
  assign l_rvalid = r_rdL;
  assign c_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

  // Counter saturates because it only advances while below the limit; L wins at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SHARE;
      r_starveCnt <= 8'd0;
      r_rdC       <= 1'b0;
      r_rdL       <= 1'b0;
    end else begin
      r_rdC <= w_cGnt & ~c_we;
      r_rdL <= w_lGnt & ~l_we;
      if (r_state == LOCKED) begin
        r_starveCnt <= 8'd0;
        if (!l_lock) begin
          r_state <= SHARE;
        end
      end else begin
        if (w_lGnt) begin
          r_starveCnt <= 8'd0;
          if (l_lock) begin
            r_state <= LOCKED;
          end
        end else if (w_conflict && (r_starveCnt < LIMIT)) begin
          r_starveCnt <= r_starveCnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-without-read RAM model on the port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we;
  logic [10:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_gnt, c_rvalid;
  logic [15:0] c_rdata;
  logic        l_req, l_we, l_lock;
  logic [10:0] l_addr;
  logic [15:0] l_wdata;
  logic        l_gnt, l_rvalid;
  logic [15:0] l_rdata;
  logic [10:0] m_addr;
  logic        m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  logic [15:0] ram [0:2047];

  int compareCount = 0;
  int failCount    = 0;

  mem_port_arbiter #(.LOG2ABITS(11), .DWIDTH(16), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_wdata;
    else      m_rdata <= ram[m_addr];
  end

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [10:0] cAddr,
                               input logic [15:0] cWdata, input logic lReq, input logic lWe,
                               input logic [10:0] lAddr, input logic [15:0] lWdata,
                               input logic lLock);
    c_req = cReq; c_we = cWe; c_addr = cAddr; c_wdata = cWdata;
    l_req = lReq; l_we = lWe; l_addr = lAddr; l_wdata = lWdata; l_lock = lLock;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic toSample;
    @(negedge clk);
  endtask

  task automatic toNext;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1, 1, 11'h123, 16'hAAAA, 1, 1, 11'h055, 16'h5555, 0);
    #1 reset = 1'b1;
    toSample;
    checkOutput("rstCGnt", 32'(c_gnt), 0);
    checkOutput("rstLGnt", 32'(l_gnt), 0);
    checkOutput("rstMWe", 32'(m_we), 0);
    checkOutput("rstCRvalid", 32'(c_rvalid), 0);
    checkOutput("rstLRvalid", 32'(l_rvalid), 0);
    checkOutput("rstMAddr", 32'(m_addr), 32'h123);
    checkOutput("rstMWdata", 32'(m_wdata), 32'hAAAA);
    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    reset = 1'b0;
    toNext;

    // Preload RAM through the C port.
    applyStimulus(1, 1, 11'h010, 16'h6180, 0, 0, 11'h000, 16'h0000, 0);
    toNext;
    applyStimulus(1, 1, 11'h100, 16'h1234, 0, 0, 11'h000, 16'h0000, 0);
    toNext;
    applyStimulus(1, 1, 11'h101, 16'h5678, 0, 0, 11'h000, 16'h0000, 0);
    toNext;

    applyStimulus(0, 0, 11'h2AA, 16'h0000, 0, 0, 11'h155, 16'h0000, 0);
    toSample;
    checkOutput("idleMAddr", 32'(m_addr), 32'h2AA);
    checkOutput("idleCGnt", 32'(c_gnt), 0);
    toNext;

    applyStimulus(1, 0, 11'h010, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("cRdGnt", 32'(c_gnt), 1);
    checkOutput("cRdLGnt", 32'(l_gnt), 0);
    checkOutput("cRdMAddr", 32'(m_addr), 32'h010);
    checkOutput("cRdMWe", 32'(m_we), 0);
    toNext;
    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("cRdRvalid", 32'(c_rvalid), 1);
    checkOutput("cRdData", 32'(c_rdata), 32'h6180);
    checkOutput("cRdLRvalid", 32'(l_rvalid), 0);
    toNext;

    applyStimulus(1, 1, 11'h7FF, 16'hBEEF, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("cWrGnt", 32'(c_gnt), 1);
    checkOutput("cWrMWe", 32'(m_we), 1);
    checkOutput("cWrMWdata", 32'(m_wdata), 32'hBEEF);
    toNext;
    applyStimulus(1, 0, 11'h7FF, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("cRbGnt", 32'(c_gnt), 1);
    checkOutput("cRbMWe", 32'(m_we), 0);
    checkOutput("cWrNoRvalid", 32'(c_rvalid), 0);
    toNext;
    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("cRbRvalid", 32'(c_rvalid), 1);
    checkOutput("cRbData", 32'(c_rdata), 32'hBEEF);
    toNext;

    for (int i = 0; i < 27; i++) begin
      applyStimulus(1, 0, 11'h010, 16'h0000, 1, 0, 11'h100, 16'h0000, 0);
      toSample;
      checkOutput($sformatf("starveC%0d", i), 32'(c_gnt), 32'((i % 9) != 8));
      checkOutput($sformatf("starveL%0d", i), 32'(l_gnt), 32'((i % 9) == 8));
      toNext;
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 11'h020, 16'h0000, 1, 1, 11'h200, 16'h0F0F, 1);
      toSample;
      checkOutput($sformatf("lockArbC%0d", i), 32'(c_gnt), 32'(i != 8));
      checkOutput($sformatf("lockArbL%0d", i), 32'(l_gnt), 32'(i == 8));
      toNext;
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 11'h020, 16'h0000, 0, 0, 11'h200, 16'h0000, 1);
      toSample;
      checkOutput($sformatf("lockIdleC%0d", i), 32'(c_gnt), 0);
      checkOutput($sformatf("lockIdleL%0d", i), 32'(l_gnt), 0);
      toNext;
    end
    applyStimulus(1, 0, 11'h020, 16'h0000, 1, 0, 11'h200, 16'h0000, 1);
    toSample;
    checkOutput("lockRdL", 32'(l_gnt), 1);
    checkOutput("lockRdC", 32'(c_gnt), 0);
    checkOutput("lockRdMAddr", 32'(m_addr), 32'h200);
    toNext;
    applyStimulus(1, 0, 11'h020, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("lockDropC", 32'(c_gnt), 0);
    checkOutput("lockLRvalid", 32'(l_rvalid), 1);
    checkOutput("lockLRdata", 32'(l_rdata), 32'h0F0F);
    toNext;
    toSample;
    checkOutput("lockAfterC", 32'(c_gnt), 1);
    toNext;

    applyStimulus(0, 0, 11'h000, 16'h0000, 1, 0, 11'h100, 16'h0000, 0);
    toSample;
    checkOutput("dualLGnt", 32'(l_gnt), 1);
    checkOutput("dualMAddrL", 32'(m_addr), 32'h100);
    toNext;
    applyStimulus(1, 0, 11'h101, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("dualCGnt", 32'(c_gnt), 1);
    checkOutput("dualLRvalid", 32'(l_rvalid), 1);
    checkOutput("dualLRdata", 32'(l_rdata), 32'h1234);
    checkOutput("dualCRvalid0", 32'(c_rvalid), 0);
    toNext;
    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("dualCRvalid", 32'(c_rvalid), 1);
    checkOutput("dualCRdata", 32'(c_rdata), 32'h5678);
    checkOutput("dualLRvalid0", 32'(l_rvalid), 0);
    toNext;

    // Leave the starvation counter part-way so the reset test proves it clears.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 11'h010, 16'h0000, 1, 0, 11'h100, 16'h0000, 0);
      toNext;
    end
    applyStimulus(1, 0, 11'h010, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toSample;
    checkOutput("preRstCGnt", 32'(c_gnt), 1);
    toNext;
    checkOutput("preRstRvalid", 32'(c_rvalid), 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstRvalid", 32'(c_rvalid), 0);
    checkOutput("midRstCGnt", 32'(c_gnt), 0);
    toSample;
    checkOutput("midRstHold", 32'(c_rvalid), 0);
    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    reset = 1'b0;
    toNext;
    toSample;
    checkOutput("postRstRvalid", 32'(c_rvalid), 0);
    toNext;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 11'h010, 16'h0000, 1, 0, 11'h100, 16'h0000, 0);
      toSample;
      checkOutput($sformatf("postRstC%0d", i), 32'(c_gnt), 32'(i != 8));
      checkOutput($sformatf("postRstL%0d", i), 32'(l_gnt), 32'(i == 8));
      toNext;
    end

    applyStimulus(0, 0, 11'h000, 16'h0000, 0, 0, 11'h000, 16'h0000, 0);
    toNext;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
